// File: rtl/twos_comp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : twos_comp_pkg                                                     |
// | Brief  : Shared FSM encodings and default width for the serial negator.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package twos_comp_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

endpackage : twos_comp_pkg
`default_nettype wire

// File: rtl/serial_neg_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : serial_neg_core                                                   |
// | Brief  : 1-bit Mealy two's-complement core (copy until first 1, invert).   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module serial_neg_core (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    input  logic neg,
    input  logic bit_in,
    output logic bit_out
);

    logic r_seen_one;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_seen_one <= 1'b0;
        end else if (clr) begin
            r_seen_one <= 1'b0;
        end else if (en) begin
            r_seen_one <= r_seen_one | bit_in;
        end
    end

    // Bits above the lowest set bit are inverted when negating.
    assign bit_out = bit_in ^ (neg & r_seen_one);

endmodule : serial_neg_core
`default_nettype wire

// File: rtl/twos_comp_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : twos_comp_seq_ctrl                                                |
// | Brief  : Word-level valid/ready controller around the serial negator.      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module twos_comp_seq_ctrl
    import twos_comp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_neg,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_ovf,
    output logic             busy
);

    localparam int               c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);

    logic [1:0]         r_state;
    logic               r_live;
    logic [WIDTH-1:0]   r_in_sr;
    logic [WIDTH-1:0]   r_res_sr;
    logic [WIDTH-1:0]   r_m_data;
    logic               r_m_ovf;
    logic               r_neg;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_accept;
    logic               w_shift;
    logic               w_bit;
    logic               w_out_bit;
    logic [WIDTH-1:0]   w_res_next;

    assign w_shift    = (r_state == ST_SHIFT);
    assign w_accept   = s_valid & s_ready;
    assign w_bit      = r_in_sr[0];
    assign w_res_next = {w_out_bit, r_res_sr[WIDTH-1:1]};

    serial_neg_core u_core (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (w_accept),
        .en      (w_shift),
        .neg     (r_neg),
        .bit_in  (w_bit),
        .bit_out (w_out_bit)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_live   <= 1'b0;
            r_in_sr  <= '0;
            r_res_sr <= '0;
            r_m_data <= '0;
            r_m_ovf  <= 1'b0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_in_sr <= s_data;
                        r_neg   <= s_neg;
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_in_sr  <= r_in_sr >> 1;
                    r_res_sr <= w_res_next;
                    if (r_cnt == c_last_bit) begin
                        r_m_data <= w_res_next;
                        // With neg and a set bit, out_bit is 1 only if no earlier 1 was seen.
                        r_m_ovf  <= r_neg & w_bit & w_out_bit;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                ST_DONE: begin
                    if (m_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_ready = r_live & (r_state == ST_IDLE);
    assign m_valid = (r_state == ST_DONE);
    assign busy    = w_shift | m_valid;
    assign m_data  = r_m_data;
    assign m_ovf   = r_m_ovf;

endmodule : twos_comp_seq_ctrl
`default_nettype wire
